mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences the instruction-fetch and data-memory requests of the pipelined CPU onto the single shared RAM port. Sits between the request unit and instruction fetch on one side and the RAM on the other, and owns all ordering on that port. It grants one access at a time and holds it until the RAM acknowledges. Data has priority, with a streak limit that prevents instruction-fetch starvation. It produces the wait/load signals from which the datapath derives ihit and dhit.

## Interface
- WORD_W, 32: address and data width (word_t).
- DSTREAK, 4: max consecutive data grants while a fetch is pending; range 1..15.
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- iREN  in  1  instruction fetch request.
- iaddr  in  WORD_W  fetch address.
- dREN  in  1  data read request (request unit dmemREN).
- dWEN  in  1  data write request (request unit dmemWEN).
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  write data.
- iwait  out  1  low for exactly the completing cycle of a fetch.
- dwait  out  1  low for exactly the completing cycle of a data access.
- iload  out  WORD_W  fetch data; valid only while iwait=0.
- dload  out  WORD_W  read data; valid only while dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data; valid with ram_ack.
- ram_ack  in  1  single-cycle completion pulse from RAM.

## Operation
- States: IDLE, IACC, DACC.
- IDLE:
  - dreq = dREN|dWEN.
  - If dreq and (!iREN or streak<DSTREAK): go to DACC.
  - Else if iREN: go to IACC.
  - Else: stay in IDLE.
- On each grant, latch the address, store data and op. If dREN and dWEN are both high, dWEN wins and the latched op is a write.
- IACC: ramREN=1, ramaddr=latched iaddr. On ram_ack, iwait=0, iload=ramload, next state IDLE.
- DACC:
  - ramREN or ramWEN=1 according to the latched op; ramaddr=latched daddr; ramstore=latched dstore.
  - On ram_ack, dwait=0, dload=ramload (don't-care for writes), next state IDLE.
- Non-preemptive: changes to requests or addresses after a grant are ignored until ack. Requesters hold their request until their wait is low.
- ram_ack in IDLE is ignored and has no effect.
- Streak counter, 4 bits, updated at grant time:
  - Data grant with iREN=1: streak+1.
  - Data grant with iREN=0: streak=0.
  - Instruction grant: streak=0.
  - When streak==DSTREAK and both requests are pending, the instruction is granted.
- iload and dload are driven from ramload at all times. Consumers qualify them with their wait signal.
- iwait=1 and dwait=1 in every cycle except the respective ack cycle. RAM strobes are 0 in IDLE.

## Timing
- Reset (nRST low at an edge):
  - State becomes IDLE and streak becomes 0.
  - Outputs settle to: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Reset mid-access abandons the access. No wait deasserts for it.
- Request visible in IDLE at cycle t → strobe asserted from cycle t+1.
- ram_ack in cycle t+k (k≥1) → the matching wait is low in t+k, IDLE at t+k+1.
- Minimum access time is 2 cycles; back-to-back accesses occur every k+1 cycles.
- Strobes and address are stable for the whole access and drop in the cycle after ack.
- Simultaneous iREN and dreq in IDLE: data is granted unless streak==DSTREAK.
- ram_ack asserted for more than 1 cycle: only the first cycle counts. The state has already returned to IDLE when the extra cycle arrives.

## Test plan
- Reset: hold nRST=0 for 2 cycles with all requests high → iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0.
- Single fetch: iREN=1, iaddr=0x100, ack after 3 cycles with ramload=0xDEADBEEF → ramREN high for 3 cycles, iwait=0 with iload=0xDEADBEEF in the ack cycle.
- Write: dWEN=1, daddr=0x200, dstore=0x12345678, ack on the first cycle → ramWEN=1, ramaddr=0x200, ramstore=0x12345678; dwait low for exactly 1 cycle.
- Priority and streak:
  - Stimulus: iREN and dREN held high; RAM acks every access; DSTREAK=4.
  - Required grant order: D,D,D,D,I, then D,D,D,D,I repeating.
- Stability: change daddr from 0x200 to 0x300 mid-access → ramaddr stays 0x200 until ack.
- Reset mid-access: assert nRST=0 during DACC, then later pulse ram_ack → IDLE, dwait stays 1, no new strobe.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and RAM signals that meet at the shared memory arbiter.
// The arbiter connects through the master modport and the environment through the slave modport.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              iwait;
    logic              dwait;
    logic [WORD_W-1:0] iload;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ram_ack;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port, one access at a time.
// Data wins ties unless DSTREAK data grants in a row have already starved a pending fetch.
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int DSTREAK = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    mem_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    localparam logic [3:0] DSTREAK_LIM = 4'(DSTREAK);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_streak;
    logic [3:0]        w_streak_nxt;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_store;
    logic              r_ren;
    logic              r_wen;
    logic              w_dreq;
    logic              w_dgrant;
    logic              w_igrant;
    logic              w_done;

    // State and streak register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_streak <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Grant decision and next state; requests are only looked at in IDLE
    always_comb begin
        w_dreq       = bus.dREN | bus.dWEN;
        w_dgrant     = 1'b0;
        w_igrant     = 1'b0;
        w_done       = 1'b0;
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        case (r_state)
            IDLE: begin
                if (w_dreq && (!bus.iREN || (r_streak < DSTREAK_LIM))) begin
                    w_dgrant     = 1'b1;
                    w_state_nxt  = DACC;
                    w_streak_nxt = bus.iREN ? (r_streak + 4'd1) : 4'd0;
                end else if (bus.iREN) begin
                    w_igrant     = 1'b1;
                    w_state_nxt  = IACC;
                    w_streak_nxt = 4'd0;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            IACC, DACC: begin
                if (bus.ram_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Access registers: captured at grant so later requester changes cannot disturb the RAM
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_addr  <= {WORD_W{1'b0}};
            r_store <= {WORD_W{1'b0}};
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
        end else if (w_dgrant || w_igrant) begin
            r_addr  <= w_dgrant ? bus.daddr : bus.iaddr;
            r_store <= bus.dstore;
            r_ren   <= w_igrant | ~bus.dWEN;
            r_wen   <= w_dgrant & bus.dWEN;
        end else if (w_done) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            r_ren   <= r_ren;
            r_wen   <= r_wen;
        end
    end

    // Waits must drop in the ack cycle itself, so they follow ram_ack combinationally
    assign bus.iwait    = ~((r_state == IACC) & bus.ram_ack);
    assign bus.dwait    = ~((r_state == DACC) & bus.ram_ack);
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.ramREN   = r_ren;
    assign bus.ramWEN   = r_wen;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table followed by multi-cycle
// sequences for priority/streak, address stability and reset during an access.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.WORD_W(32)) bus ();

    mem_arbiter #(.WORD_W(32), .DSTREAK(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst, iren, dren, dwen, ack;
        logic [31:0] iaddr, daddr, dstore, rload;
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_load;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw, input logic ak,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] rl);
        bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw; bus.ram_ack = ak;
        bus.iaddr = ia; bus.daddr = da; bus.dstore = ds; bus.ramload = rl;
    endtask

    initial begin
        // nrst iren dren dwen ack | iaddr daddr dstore rload | iwait dwait ren wen | addr store load
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'hAAAA5555, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = vecs[0];
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0,
                     1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0};
        vecs[5]  = vecs[4];
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF,
                     1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h12345678, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h12345678, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'hCAFE0001,
                     1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 32'hCAFE0001};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 32'h0};

        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();

        // Per-cycle table: inputs driven just after the edge, outputs checked mid-cycle
        for (int i = 0; i < 11; i++) begin
            step();
            nRST = vecs[i].nrst;
            drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].ack,
                  vecs[i].iaddr, vecs[i].daddr, vecs[i].dstore, vecs[i].rload);
            #2;
            chk($sformatf("v%0d iwait", i),    {31'd0, bus.iwait},  {31'd0, vecs[i].e_iwait});
            chk($sformatf("v%0d dwait", i),    {31'd0, bus.dwait},  {31'd0, vecs[i].e_dwait});
            chk($sformatf("v%0d ramREN", i),   {31'd0, bus.ramREN}, {31'd0, vecs[i].e_ren});
            chk($sformatf("v%0d ramWEN", i),   {31'd0, bus.ramWEN}, {31'd0, vecs[i].e_wen});
            chk($sformatf("v%0d ramaddr", i),  bus.ramaddr,  vecs[i].e_addr);
            chk($sformatf("v%0d ramstore", i), bus.ramstore, vecs[i].e_store);
            chk($sformatf("v%0d iload", i),    bus.iload,    vecs[i].e_load);
            chk($sformatf("v%0d dload", i),    bus.dload,    vecs[i].e_load);
        end

        // Priority/streak: both requesters always pending, every access acked at once
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h500, 32'h0, 32'h0);
        for (int g = 0; g < 10; g++) begin
            logic        found;
            logic        got_d;
            logic        exp_d;
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                step();
                bus.ram_ack = 1'b0;
                #2;
                if (bus.ramREN || bus.ramWEN) found = 1'b1;
            end
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL prio grant %0d: no strobe within 8 cycles", g);
            end
            exp_d = ((g % 5) != 4);
            got_d = (bus.ramaddr == 32'h500);
            chk($sformatf("prio grant %0d is_data", g), {31'd0, got_d}, {31'd0, exp_d});
            chk($sformatf("prio grant %0d ramWEN", g), {31'd0, bus.ramWEN}, 32'd0);
            bus.ram_ack = 1'b1;
            bus.ramload = 32'h1000 + 32'(g);
            if (g == 9) begin
                bus.iREN = 1'b0;
                bus.dREN = 1'b0;
            end
            #1;
            chk($sformatf("prio grant %0d wait", g),
                {30'd0, bus.iwait, bus.dwait}, exp_d ? 32'd2 : 32'd1);
        end
        step();
        bus.ram_ack = 1'b0;
        #2;
        chk("prio idle ramREN", {31'd0, bus.ramREN}, 32'd0);

        // Stability: daddr changes mid-access must not reach the RAM
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0);
        step();
        bus.daddr = 32'h300;
        #2;
        chk("stab ramREN", {31'd0, bus.ramREN}, 32'd1);
        chk("stab addr c1", bus.ramaddr, 32'h200);
        step();
        #2;
        chk("stab addr c2", bus.ramaddr, 32'h200);
        step();
        bus.ram_ack = 1'b1;
        bus.ramload = 32'h55AA55AA;
        #2;
        chk("stab addr ack", bus.ramaddr, 32'h200);
        chk("stab dwait ack", {31'd0, bus.dwait}, 32'd0);
        chk("stab dload", bus.dload, 32'h55AA55AA);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("stab after ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("stab after dwait", {31'd0, bus.dwait}, 32'd1);

        // Reset mid-access: the pending write is abandoned and a late ack is ignored
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600, 32'h77, 32'h0);
        step();
        #2;
        chk("rst pre ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        step();
        nRST = 1'b0;
        bus.dWEN = 1'b0;
        #2;
        chk("rst hold dwait", {31'd0, bus.dwait}, 32'd1);
        step();
        nRST = 1'b1;
        bus.ram_ack = 1'b1;
        #2;
        chk("rst ack dwait", {31'd0, bus.dwait}, 32'd1);
        chk("rst ack ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("rst ack ramaddr", bus.ramaddr, 32'h0);
        step();
        bus.ram_ack = 1'b0;
        #2;
        chk("rst post ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("rst post ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("rst post dwait", {31'd0, bus.dwait}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
